// File: rtl/md_scheduler_pkg.sv
// Shared encodings for the multiply/divide scheduler: request opcodes, FSM states, op-class helpers.
// Pure definitions; no logic, latency or flow control of its own.
package md_sched_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MFHI  = 3'd6,
        OP_MFLO  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MUL = 2'd1,
        ST_WAIT_DIV = 2'd2,
        ST_DRAIN    = 2'd3
    } md_state_e;

    function automatic logic is_signed_op(md_op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/md_scheduler_if.sv
// Decode-side request/move-from bus plus the shared mul/div unit start/complete bus.
// slave = scheduler view, master = decode/unit/environment view.
interface md_scheduler_if;
    import md_sched_pkg::*;

    logic         req_valid;
    md_op_e       req_op;
    logic [31:0]  req_src1;
    logic [31:0]  req_src2;
    logic         req_ready;
    logic         flush;
    logic         mul_en;
    logic         div_en;
    logic         md_signed;
    logic [31:0]  md_src1;
    logic [31:0]  md_src2;
    logic         mul_complete;
    logic [63:0]  mul_result;
    logic         div_complete;
    logic [31:0]  div_quotient;
    logic [31:0]  div_remainder;
    logic         mf_valid;
    logic [31:0]  mf_data;
    logic         md_busy;
    logic [31:0]  hi;
    logic [31:0]  lo;
    logic         timeout_err;

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, flush,
               mul_complete, mul_result, div_complete, div_quotient, div_remainder,
        output req_ready, mul_en, div_en, md_signed, md_src1, md_src2,
               mf_valid, mf_data, md_busy, hi, lo, timeout_err
    );

    modport master (
        output req_valid, req_op, req_src1, req_src2, flush,
               mul_complete, mul_result, div_complete, div_quotient, div_remainder,
        input  req_ready, mul_en, div_en, md_signed, md_src1, md_src2,
               mf_valid, mf_data, md_busy, hi, lo, timeout_err
    );

endinterface

// File: rtl/md_hilo_regs.sv
// Architectural HI/LO register pair with individual and paired 64-bit write ports.
// Writes land on the next rising edge; reads are the register outputs; no backpressure.
module md_hilo_regs (
    input  logic        clk,
    input  logic        reset,
    input  logic        hi_we,
    input  logic [31:0] hi_wd,
    input  logic        lo_we,
    input  logic [31:0] lo_wd,
    input  logic        pair_we,
    input  logic [63:0] pair_wd,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // Paired write (unit result) takes priority; the scheduler never raises both at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (pair_we) begin
            hi <= pair_wd[63:32];
            lo <= pair_wd[31:0];
        end else begin
            if (hi_we) hi <= hi_wd;
            if (lo_we) lo <= lo_wd;
        end
    end

endmodule

// File: rtl/md_scheduler.sv
// Issues MULT/DIV start pulses to the shared units, commits results to HI/LO, serves MTxx/MFxx.
// Start/move-from outputs are combinational in the accept cycle; results visible the cycle after complete.
module md_scheduler
    import md_sched_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic           clk,
    input  logic           reset,
    md_scheduler_if.slave  bus
);

    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    md_state_e        state, state_nxt;
    logic [CNT_W-1:0] wd_cnt;
    logic             wd_hit;
    logic             cnt_clr, cnt_inc, to_set;
    logic             timeout_err;

    logic             accept;
    logic             mul_en, div_en, md_signed, mf_valid;
    logic [31:0]      md_src1, md_src2, mf_data;
    logic             hi_we, lo_we, pair_we;
    logic [63:0]      pair_wd;
    logic [31:0]      hi_q, lo_q;

    assign wd_hit = (wd_cnt == WD_LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        mul_en    = 1'b0;
        div_en    = 1'b0;
        md_signed = 1'b0;
        md_src1   = '0;
        md_src2   = '0;
        mf_valid  = 1'b0;
        mf_data   = '0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        pair_we   = 1'b0;
        pair_wd   = '0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        to_set    = 1'b0;

        case (state)
            ST_IDLE: begin
                accept = bus.req_valid & ~bus.flush;
                if (accept) begin
                    case (bus.req_op)
                        OP_MULT, OP_MULTU: begin
                            mul_en    = 1'b1;
                            md_signed = is_signed_op(bus.req_op);
                            md_src1   = bus.req_src1;
                            md_src2   = bus.req_src2;
                            cnt_clr   = 1'b1;
                            state_nxt = ST_WAIT_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            div_en    = 1'b1;
                            md_signed = is_signed_op(bus.req_op);
                            md_src1   = bus.req_src1;
                            md_src2   = bus.req_src2;
                            cnt_clr   = 1'b1;
                            state_nxt = ST_WAIT_DIV;
                        end
                        OP_MTHI: hi_we = 1'b1;
                        OP_MTLO: lo_we = 1'b1;
                        OP_MFHI: begin
                            mf_valid = 1'b1;
                            mf_data  = hi_q;
                        end
                        OP_MFLO: begin
                            mf_valid = 1'b1;
                            mf_data  = lo_q;
                        end
                    endcase
                end
            end
            // Completion beats the watchdog; the watchdog beats a flush so a hung unit can't strand DRAIN.
            ST_WAIT_MUL: begin
                cnt_inc = 1'b1;
                if (bus.mul_complete) begin
                    state_nxt = ST_IDLE;
                    pair_we   = ~bus.flush;
                    pair_wd   = bus.mul_result;
                end else if (wd_hit) begin
                    to_set    = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (bus.flush) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_WAIT_DIV: begin
                cnt_inc = 1'b1;
                if (bus.div_complete) begin
                    state_nxt = ST_IDLE;
                    pair_we   = ~bus.flush;
                    pair_wd   = {bus.div_remainder, bus.div_quotient};
                end else if (wd_hit) begin
                    to_set    = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (bus.flush) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                cnt_inc = 1'b1;
                if (bus.mul_complete || bus.div_complete) begin
                    state_nxt = ST_IDLE;
                end else if (wd_hit) begin
                    to_set    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                         wd_cnt <= '0;
        else if (cnt_clr)                  wd_cnt <= '0;
        else if (cnt_inc && wd_cnt != '1)  wd_cnt <= wd_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       timeout_err <= 1'b0;
        else if (to_set) timeout_err <= 1'b1;
    end

    md_hilo_regs u_hilo (
        .clk     (clk),
        .reset   (reset),
        .hi_we   (hi_we),
        .hi_wd   (bus.req_src1),
        .lo_we   (lo_we),
        .lo_wd   (bus.req_src1),
        .pair_we (pair_we),
        .pair_wd (pair_wd),
        .hi      (hi_q),
        .lo      (lo_q)
    );

    assign bus.req_ready   = (state == ST_IDLE);
    assign bus.md_busy     = (state != ST_IDLE);
    assign bus.mul_en      = mul_en;
    assign bus.div_en      = div_en;
    assign bus.md_signed   = md_signed;
    assign bus.md_src1     = md_src1;
    assign bus.md_src2     = md_src2;
    assign bus.mf_valid    = mf_valid;
    assign bus.mf_data     = mf_data;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.timeout_err = timeout_err;

endmodule

// File: tb/tb_md_scheduler.sv
// Directed bench for md_scheduler with an 8-cycle watchdog; expected values are hand-computed constants.
module tb_md_scheduler;
    import md_sched_pkg::*;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    md_scheduler_if bus ();

    md_scheduler #(
        .TIMEOUT_CYCLES (8),
        .CNT_W          (4)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        bus.req_valid     = 1'b0;
        bus.req_op        = OP_MULT;
        bus.req_src1      = '0;
        bus.req_src2      = '0;
        bus.flush         = 1'b0;
        bus.mul_complete  = 1'b0;
        bus.mul_result    = '0;
        bus.div_complete  = 1'b0;
        bus.div_quotient  = '0;
        bus.div_remainder = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset = 1'b1;
        clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",   64'(bus.md_busy), 64'd0);
        chk("rst_hi",     64'(bus.hi), 64'd0);
        chk("rst_lo",     64'(bus.lo), 64'd0);
        chk("rst_to",     64'(bus.timeout_err), 64'd0);
        chk("rst_mul_en", 64'(bus.mul_en), 64'd0);
        chk("rst_div_en", 64'(bus.div_en), 64'd0);
        chk("rst_mf_vld", 64'(bus.mf_valid), 64'd0);
        reset = 1'b0;
        tick();
        chk("idle_ready", 64'(bus.req_ready), 64'd1);

        // MULT -2 * 3, unit completes in the 4th cycle after accept
        bus.req_valid = 1'b1;
        bus.req_op    = OP_MULT;
        bus.req_src1  = 32'hFFFF_FFFE;
        bus.req_src2  = 32'd3;
        #1;
        chk("mult_mul_en", 64'(bus.mul_en), 64'd1);
        chk("mult_div_en", 64'(bus.div_en), 64'd0);
        chk("mult_signed", 64'(bus.md_signed), 64'd1);
        chk("mult_src1",   64'(bus.md_src1), 64'hFFFF_FFFE);
        chk("mult_src2",   64'(bus.md_src2), 64'd3);
        tick();
        clear();
        #1;
        chk("mult_pulse_once", 64'(bus.mul_en), 64'd0);
        chk("mult_busy",       64'(bus.md_busy), 64'd1);
        chk("mult_ready",      64'(bus.req_ready), 64'd0);
        chk("mult_src1_hold",  64'(bus.md_src1), 64'd0);
        repeat (2) begin
            tick();
            chk("mult_wait_busy", 64'(bus.md_busy), 64'd1);
            chk("mult_wait_en",   64'(bus.mul_en), 64'd0);
        end
        tick();
        bus.mul_complete = 1'b1;
        bus.mul_result   = 64'hFFFF_FFFF_FFFF_FFFA;
        #1;
        chk("mult_cmp_busy",  64'(bus.md_busy), 64'd1);
        chk("mult_cmp_ready", 64'(bus.req_ready), 64'd0);
        chk("mult_cmp_hi",    64'(bus.hi), 64'd0);
        tick();
        clear();
        #1;
        chk("mult_hi",   64'(bus.hi), 64'hFFFF_FFFF);
        chk("mult_lo",   64'(bus.lo), 64'hFFFF_FFFA);
        chk("mult_idle", 64'(bus.md_busy), 64'd0);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_MFLO;
        #1;
        chk("mflo_vld",  64'(bus.mf_valid), 64'd1);
        chk("mflo_dat",  64'(bus.mf_data), 64'hFFFF_FFFA);
        chk("mflo_noen", 64'(bus.mul_en), 64'd0);
        tick();
        clear();

        // DIVU 100/7 with an MTHI held on the bus that must not be taken while busy
        bus.req_valid = 1'b1;
        bus.req_op    = OP_DIVU;
        bus.req_src1  = 32'd100;
        bus.req_src2  = 32'd7;
        #1;
        chk("divu_div_en", 64'(bus.div_en), 64'd1);
        chk("divu_mul_en", 64'(bus.mul_en), 64'd0);
        chk("divu_signed", 64'(bus.md_signed), 64'd0);
        tick();
        clear();
        bus.req_valid = 1'b1;
        bus.req_op    = OP_MTHI;
        bus.req_src1  = 32'h0000_0BAD;
        #1;
        chk("divu_w1_ready", 64'(bus.req_ready), 64'd0);
        chk("divu_w1_en",    64'(bus.div_en), 64'd0);
        tick();
        chk("divu_w2_ready", 64'(bus.req_ready), 64'd0);
        tick();
        bus.div_complete  = 1'b1;
        bus.div_quotient  = 32'd14;
        bus.div_remainder = 32'd2;
        #1;
        chk("divu_cmp_ready", 64'(bus.req_ready), 64'd0);
        tick();
        clear();
        #1;
        chk("divu_hi", 64'(bus.hi), 64'd2);
        chk("divu_lo", 64'(bus.lo), 64'd14);

        // Preload HI/LO, then flush a DIV three cycles in
        bus.req_valid = 1'b1;
        bus.req_op    = OP_MTHI;
        bus.req_src1  = 32'h11;
        tick();
        bus.req_op    = OP_MTLO;
        bus.req_src1  = 32'h22;
        tick();
        chk("pre_hi", 64'(bus.hi), 64'h11);
        chk("pre_lo", 64'(bus.lo), 64'h22);
        bus.req_op    = OP_DIV;
        bus.req_src1  = 32'd50;
        bus.req_src2  = 32'd5;
        #1;
        chk("div_en",     64'(bus.div_en), 64'd1);
        chk("div_signed", 64'(bus.md_signed), 64'd1);
        tick();
        clear();
        tick();
        tick();
        bus.flush = 1'b1;
        #1;
        chk("fl_busy_c3", 64'(bus.md_busy), 64'd1);
        tick();
        clear();
        #1;
        chk("drain_busy",  64'(bus.md_busy), 64'd1);
        chk("drain_ready", 64'(bus.req_ready), 64'd0);
        tick();
        bus.div_complete  = 1'b1;
        bus.div_quotient  = 32'd10;
        bus.div_remainder = 32'd0;
        #1;
        chk("drain_cmp_busy", 64'(bus.md_busy), 64'd1);
        tick();
        clear();
        #1;
        chk("drain_done", 64'(bus.md_busy), 64'd0);
        chk("drain_hi",   64'(bus.hi), 64'h11);
        chk("drain_lo",   64'(bus.lo), 64'h22);

        // Moves, including flushed move-to and move-from
        bus.req_valid = 1'b1;
        bus.req_op    = OP_MTHI;
        bus.req_src1  = 32'hDEAD_BEEF;
        tick();
        bus.req_op    = OP_MFHI;
        #1;
        chk("mfhi_vld", 64'(bus.mf_valid), 64'd1);
        chk("mfhi_dat", 64'(bus.mf_data), 64'hDEAD_BEEF);
        tick();
        bus.req_op    = OP_MTLO;
        bus.req_src1  = 32'h5555;
        bus.flush     = 1'b1;
        #1;
        chk("mtlo_fl_ready", 64'(bus.req_ready), 64'd1);
        tick();
        bus.req_op    = OP_MFHI;
        #1;
        chk("mfhi_fl_vld", 64'(bus.mf_valid), 64'd0);
        chk("mfhi_fl_dat", 64'(bus.mf_data), 64'd0);
        tick();
        clear();
        #1;
        chk("mtlo_fl_lo", 64'(bus.lo), 64'h22);

        // Watchdog: MULT with no completion for 8 wait cycles
        bus.req_valid = 1'b1;
        bus.req_op    = OP_MULT;
        bus.req_src1  = 32'd2;
        bus.req_src2  = 32'd3;
        tick();
        clear();
        repeat (7) tick();
        chk("to_c8_busy", 64'(bus.md_busy), 64'd1);
        chk("to_c8_err",  64'(bus.timeout_err), 64'd0);
        tick();
        chk("to_err",   64'(bus.timeout_err), 64'd1);
        chk("to_busy",  64'(bus.md_busy), 64'd0);
        chk("to_ready", 64'(bus.req_ready), 64'd1);
        bus.mul_complete = 1'b1;
        bus.mul_result   = 64'h1234_5678_8765_4321;
        tick();
        clear();
        #1;
        chk("late_hi",  64'(bus.hi), 64'hDEAD_BEEF);
        chk("late_lo",  64'(bus.lo), 64'h22);
        chk("to_stick", 64'(bus.timeout_err), 64'd1);

        // Async reset mid-WAIT_MUL, then a stale completion
        bus.req_valid = 1'b1;
        bus.req_op    = OP_MULT;
        bus.req_src1  = 32'd5;
        bus.req_src2  = 32'd6;
        tick();
        clear();
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy",  64'(bus.md_busy), 64'd0);
        chk("arst_hi",    64'(bus.hi), 64'd0);
        chk("arst_lo",    64'(bus.lo), 64'd0);
        chk("arst_to",    64'(bus.timeout_err), 64'd0);
        chk("arst_ready", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.mul_complete = 1'b1;
        bus.mul_result   = 64'hAAAA_AAAA_5555_5555;
        tick();
        clear();
        #1;
        chk("stale_hi",   64'(bus.hi), 64'd0);
        chk("stale_lo",   64'(bus.lo), 64'd0);
        chk("stale_busy", 64'(bus.md_busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
